// File: rtl/alu_pkg.sv
// Shared ALU control encodings: ALU select codes, ALUOp field values and R-type funct constants.
package alu_pkg;

  localparam logic [3:0] SEL_AND = 4'd0;
  localparam logic [3:0] SEL_OR  = 4'd1;
  localparam logic [3:0] SEL_ADD = 4'd2;
  localparam logic [3:0] SEL_SUB = 4'd6;
  localparam logic [3:0] SEL_SLT = 4'd7;
  localparam logic [3:0] SEL_NOR = 4'd12;
  localparam logic [3:0] SEL_ILL = 4'd15;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_OR    = 2'b11
  } alu_op_e;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;
  localparam logic [5:0] FUNCT_NOR = 6'h27;

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control: ALUOp + funct -> ALU select code and illegal-op flag.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] alu_op_i,
  input  logic [5:0] funct_i,
  output logic [3:0] sel_o,
  output logic       illegal_o
);

  always_comb begin
    sel_o     = SEL_ILL;
    illegal_o = 1'b0;
    case (alu_op_e'(alu_op_i))
      ALUOP_ADD: sel_o = SEL_ADD;
      ALUOP_SUB: sel_o = SEL_SUB;
      ALUOP_OR:  sel_o = SEL_OR;
      ALUOP_RTYPE: begin
        case (funct_i)
          FUNCT_ADD: sel_o = SEL_ADD;
          FUNCT_SUB: sel_o = SEL_SUB;
          FUNCT_AND: sel_o = SEL_AND;
          FUNCT_OR:  sel_o = SEL_OR;
          FUNCT_SLT: sel_o = SEL_SLT;
          FUNCT_NOR: sel_o = SEL_NOR;
          default: begin
            sel_o     = SEL_ILL;
            illegal_o = 1'b1;
          end
        endcase
      end
      default: sel_o = SEL_ILL;
    endcase
  end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX operand stage: one-slot skid holding decoded ALU control and operands,
// with EX/MEM and MEM/WB forwarding applied combinationally on the held slot.
module ex_operand_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int REGW  = 5
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             IdValid,
  output logic             IdReady,
  input  logic [1:0]       IdAluOp,
  input  logic [5:0]       IdFunct,
  input  logic             IdAluSrc,
  input  logic [REGW-1:0]  IdRs,
  input  logic [REGW-1:0]  IdRt,
  input  logic [WIDTH-1:0] IdRsData,
  input  logic [WIDTH-1:0] IdRtData,
  input  logic [WIDTH-1:0] IdImm,
  input  logic             Flush,
  input  logic             MemRegWrite,
  input  logic             WbRegWrite,
  input  logic [REGW-1:0]  MemRd,
  input  logic [REGW-1:0]  WbRd,
  input  logic [WIDTH-1:0] MemResult,
  input  logic [WIDTH-1:0] WbResult,
  output logic             ExValid,
  input  logic             ExReady,
  output logic [3:0]       Sel,
  output logic [WIDTH-1:0] DataIn1,
  output logic [WIDTH-1:0] DataIn2,
  output logic             IllegalOp
);

  logic             valid_q,  valid_d;
  logic [3:0]       sel_q,    sel_d;
  logic             ill_q,    ill_d;
  logic             alusrc_q, alusrc_d;
  logic [REGW-1:0]  rs_q,     rs_d;
  logic [REGW-1:0]  rt_q,     rt_d;
  logic [WIDTH-1:0] rsval_q,  rsval_d;
  logic [WIDTH-1:0] rtval_q,  rtval_d;
  logic [WIDTH-1:0] imm_q,    imm_d;

  logic [3:0]       dec_sel;
  logic             dec_ill;
  logic [WIDTH-1:0] rs_fwd;
  logic [WIDTH-1:0] rt_fwd;
  logic             accept;
  logic             consume;
  logic             stall;

  alu_ctrl_decode u_dec (
    .alu_op_i  (IdAluOp),
    .funct_i   (IdFunct),
    .sel_o     (dec_sel),
    .illegal_o (dec_ill)
  );

  // MEM is the younger producer, so it wins over WB; register 0 never forwards.
  always_comb begin
    rs_fwd = rsval_q;
    if (MemRegWrite && (MemRd == rs_q) && (rs_q != '0))
      rs_fwd = MemResult;
    else if (WbRegWrite && (WbRd == rs_q) && (rs_q != '0))
      rs_fwd = WbResult;
  end

  always_comb begin
    rt_fwd = rtval_q;
    if (MemRegWrite && (MemRd == rt_q) && (rt_q != '0))
      rt_fwd = MemResult;
    else if (WbRegWrite && (WbRd == rt_q) && (rt_q != '0))
      rt_fwd = WbResult;
  end

  assign IdReady = !valid_q || ExReady;
  assign accept  = IdValid && IdReady && !Flush;
  assign consume = valid_q && ExReady;
  assign stall   = valid_q && !ExReady;

  always_comb begin
    valid_d  = valid_q;
    sel_d    = sel_q;
    ill_d    = ill_q;
    alusrc_d = alusrc_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rsval_d  = rsval_q;
    rtval_d  = rtval_q;
    imm_d    = imm_q;
    if (Flush) begin
      valid_d  = 1'b0;
      sel_d    = '0;
      ill_d    = 1'b0;
      alusrc_d = 1'b0;
      rs_d     = '0;
      rt_d     = '0;
      rsval_d  = '0;
      rtval_d  = '0;
      imm_d    = '0;
    end else if (accept) begin
      valid_d  = 1'b1;
      sel_d    = dec_sel;
      ill_d    = dec_ill;
      alusrc_d = IdAluSrc;
      rs_d     = IdRs;
      rt_d     = IdRt;
      rsval_d  = IdRsData;
      rtval_d  = IdRtData;
      imm_d    = IdImm;
    end else if (consume) begin
      valid_d = 1'b0;
      ill_d   = 1'b0;
    end else if (stall) begin
      // Capture forwarded values so a producer retiring mid-stall is not lost.
      rsval_d = rs_fwd;
      rtval_d = rt_fwd;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      valid_q  <= 1'b0;
      sel_q    <= '0;
      ill_q    <= 1'b0;
      alusrc_q <= 1'b0;
      rs_q     <= '0;
      rt_q     <= '0;
      rsval_q  <= '0;
      rtval_q  <= '0;
      imm_q    <= '0;
    end else begin
      valid_q  <= valid_d;
      sel_q    <= sel_d;
      ill_q    <= ill_d;
      alusrc_q <= alusrc_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rsval_q  <= rsval_d;
      rtval_q  <= rtval_d;
      imm_q    <= imm_d;
    end
  end

  assign ExValid   = valid_q;
  assign Sel       = sel_q;
  assign IllegalOp = ill_q;
  assign DataIn1   = rs_fwd;
  assign DataIn2   = alusrc_q ? imm_q : rt_fwd;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: decode, forwarding, stall refresh, flush, streaming, reset.
module tb_ex_operand_stage;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        IdValid;
  logic        IdReady;
  logic [1:0]  IdAluOp;
  logic [5:0]  IdFunct;
  logic        IdAluSrc;
  logic [4:0]  IdRs, IdRt;
  logic [31:0] IdRsData, IdRtData, IdImm;
  logic        Flush;
  logic        MemRegWrite, WbRegWrite;
  logic [4:0]  MemRd, WbRd;
  logic [31:0] MemResult, WbResult;
  logic        ExValid;
  logic        ExReady;
  logic [3:0]  Sel;
  logic [31:0] DataIn1, DataIn2;
  logic        IllegalOp;

  int tests = 0;
  int fails = 0;

  always #5 Clk = ~Clk;

  ex_operand_stage #(.WIDTH(32), .REGW(5)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .IdValid(IdValid), .IdReady(IdReady),
    .IdAluOp(IdAluOp), .IdFunct(IdFunct), .IdAluSrc(IdAluSrc),
    .IdRs(IdRs), .IdRt(IdRt), .IdRsData(IdRsData), .IdRtData(IdRtData), .IdImm(IdImm),
    .Flush(Flush), .MemRegWrite(MemRegWrite), .WbRegWrite(WbRegWrite),
    .MemRd(MemRd), .WbRd(WbRd), .MemResult(MemResult), .WbResult(WbResult),
    .ExValid(ExValid), .ExReady(ExReady), .Sel(Sel),
    .DataIn1(DataIn1), .DataIn2(DataIn2), .IllegalOp(IllegalOp)
  );

  // Advance past the next rising edge; inputs are then driven mid-cycle.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    IdValid = 0; IdAluOp = 2'b00; IdFunct = 6'h00; IdAluSrc = 0;
    IdRs = 0; IdRt = 0; IdRsData = 0; IdRtData = 0; IdImm = 0;
    Flush = 0; MemRegWrite = 0; WbRegWrite = 0; MemRd = 0; WbRd = 0;
    MemResult = 0; WbResult = 0; ExReady = 1;
  endtask

  task automatic offer(input logic [1:0] op, input logic [5:0] fn, input logic src,
                       input logic [4:0] rs, input logic [4:0] rt,
                       input logic [31:0] rsd, input logic [31:0] rtd, input logic [31:0] imm);
    IdValid = 1; IdAluOp = op; IdFunct = fn; IdAluSrc = src;
    IdRs = rs; IdRt = rt; IdRsData = rsd; IdRtData = rtd; IdImm = imm;
  endtask

  task automatic test_reset();
    idle_inputs();
    Rst_n = 0;
    IdValid = 1;
    step(); step();
    Rst_n = 1;
    IdValid = 0;
    #1;
    tests++; if (ExValid !== 1'b0) begin fails++; $display("FAIL reset_exvalid got %0b exp 0", ExValid); end
    tests++; if (IdReady !== 1'b1) begin fails++; $display("FAIL reset_idready got %0b exp 1", IdReady); end
    tests++; if (Sel !== 4'd0) begin fails++; $display("FAIL reset_sel got %0d exp 0", Sel); end
    tests++; if (DataIn1 !== 32'd0 || DataIn2 !== 32'd0) begin fails++; $display("FAIL reset_data got %h %h exp 0 0", DataIn1, DataIn2); end
    tests++; if (IllegalOp !== 1'b0) begin fails++; $display("FAIL reset_illegal got %0b exp 0", IllegalOp); end
  endtask

  task automatic test_rtype_add();
    offer(2'b10, 6'h20, 0, 5'd1, 5'd2, 32'd5, 32'd7, 32'd0);
    ExReady = 1;
    step();
    IdValid = 0;
    tests++; if (ExValid !== 1'b1) begin fails++; $display("FAIL add_exvalid got %0b exp 1", ExValid); end
    tests++; if (Sel !== 4'd2) begin fails++; $display("FAIL add_sel got %0d exp 2", Sel); end
    tests++; if (DataIn1 !== 32'd5 || DataIn2 !== 32'd7) begin fails++; $display("FAIL add_data got %0d %0d exp 5 7", DataIn1, DataIn2); end
    tests++; if (IdReady !== 1'b1) begin fails++; $display("FAIL add_idready got %0b exp 1", IdReady); end
    step();
    tests++; if (ExValid !== 1'b0) begin fails++; $display("FAIL add_drain got %0b exp 0", ExValid); end
  endtask

  task automatic test_forward();
    offer(2'b10, 6'h20, 0, 5'd3, 5'd4, 32'h11, 32'h44, 32'd0);
    step();
    IdValid = 0; ExReady = 0;
    MemRegWrite = 1; MemRd = 5'd3; MemResult = 32'hAA;
    WbRegWrite = 1; WbRd = 5'd3; WbResult = 32'hBB;
    #1;
    tests++; if (DataIn1 !== 32'hAA) begin fails++; $display("FAIL fwd_mem_prio got %h exp aa", DataIn1); end
    tests++; if (DataIn2 !== 32'h44) begin fails++; $display("FAIL fwd_rt_untouched got %h exp 44", DataIn2); end
    MemRegWrite = 0;
    #1;
    tests++; if (DataIn1 !== 32'hBB) begin fails++; $display("FAIL fwd_wb got %h exp bb", DataIn1); end
    WbRegWrite = 0;
    #1;
    tests++; if (DataIn1 !== 32'h11) begin fails++; $display("FAIL fwd_none got %h exp 11", DataIn1); end
    // Consume and reload with Rs=0 in the same edge.
    ExReady = 1;
    offer(2'b10, 6'h20, 0, 5'd0, 5'd0, 32'h22, 32'h33, 32'd0);
    step();
    IdValid = 0; ExReady = 0;
    MemRegWrite = 1; MemRd = 5'd0; MemResult = 32'hAA;
    WbRegWrite = 1; WbRd = 5'd0; WbResult = 32'hBB;
    #1;
    tests++; if (DataIn1 !== 32'h22 || DataIn2 !== 32'h33) begin fails++; $display("FAIL fwd_r0 got %h %h exp 22 33", DataIn1, DataIn2); end
    MemRegWrite = 0; WbRegWrite = 0; ExReady = 1;
    step();
  endtask

  task automatic test_stall_refresh();
    offer(2'b10, 6'h22, 0, 5'd6, 5'd5, 32'h1, 32'h9, 32'd0);
    step();
    IdValid = 0; ExReady = 0;
    MemRegWrite = 1; MemRd = 5'd5; MemResult = 32'h1234;
    #1;
    tests++; if (DataIn2 !== 32'h1234) begin fails++; $display("FAIL stall_c1_data got %h exp 1234", DataIn2); end
    tests++; if (IdReady !== 1'b0) begin fails++; $display("FAIL stall_c1_idready got %0b exp 0", IdReady); end
    step();
    MemRegWrite = 0;
    offer(2'b00, 6'h00, 0, 5'd5, 5'd5, 32'hDEAD, 32'hBEEF, 32'd0);
    #1;
    tests++; if (DataIn2 !== 32'h1234) begin fails++; $display("FAIL stall_c2_data got %h exp 1234", DataIn2); end
    tests++; if (IdReady !== 1'b0) begin fails++; $display("FAIL stall_c2_idready got %0b exp 0", IdReady); end
    step();
    tests++; if (DataIn2 !== 32'h1234 || Sel !== 4'd6) begin fails++; $display("FAIL stall_c3 got data %h sel %0d exp 1234 6", DataIn2, Sel); end
    tests++; if (IdReady !== 1'b0 || ExValid !== 1'b1) begin fails++; $display("FAIL stall_c3_hs got rdy %0b vld %0b exp 0 1", IdReady, ExValid); end
    IdValid = 0; ExReady = 1;
    step();
    tests++; if (ExValid !== 1'b0) begin fails++; $display("FAIL stall_release got %0b exp 0", ExValid); end
  endtask

  task automatic test_decode();
    logic [1:0] ops [9] = '{2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b01, 2'b00};
    logic [5:0] fns [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27, 6'h03, 6'h00, 6'h3F};
    logic [3:0] sels[9] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd7, 4'd12, 4'd15, 4'd6, 4'd2};
    logic       ills[9] = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    ExReady = 1;
    offer(2'b11, 6'h00, 1, 5'd1, 5'd2, 32'h10, 32'h77, 32'h0000FFFF);
    step();
    tests++; if (Sel !== 4'd1 || DataIn2 !== 32'h0000FFFF) begin fails++; $display("FAIL dec_ori got sel %0d d2 %h exp 1 0000ffff", Sel, DataIn2); end
    for (int i = 0; i < 9; i++) begin
      offer(ops[i], fns[i], 0, 5'd1, 5'd2, 32'd1, 32'd2, 32'd0);
      step();
      tests++; if (Sel !== sels[i] || IllegalOp !== ills[i]) begin fails++; $display("FAIL dec_%0d got sel %0d ill %0b exp %0d %0b", i, Sel, IllegalOp, sels[i], ills[i]); end
    end
    IdValid = 0;
    step();
  endtask

  task automatic test_flush();
    offer(2'b10, 6'h20, 0, 5'd1, 5'd2, 32'd3, 32'd4, 32'd0);
    step();
    ExReady = 0;
    Flush = 1;
    offer(2'b00, 6'h00, 0, 5'd1, 5'd2, 32'd8, 32'd9, 32'd0);
    #1;
    tests++; if (IdReady !== 1'b0) begin fails++; $display("FAIL flush_idready_hold got %0b exp 0", IdReady); end
    step();
    Flush = 0; IdValid = 0;
    tests++; if (ExValid !== 1'b0 || IllegalOp !== 1'b0) begin fails++; $display("FAIL flush_hold got vld %0b ill %0b exp 0 0", ExValid, IllegalOp); end
    ExReady = 1;
    offer(2'b10, 6'h03, 0, 5'd1, 5'd2, 32'd3, 32'd4, 32'd0);
    step();
    tests++; if (IllegalOp !== 1'b1) begin fails++; $display("FAIL flush_pre_ill got %0b exp 1", IllegalOp); end
    Flush = 1;
    offer(2'b00, 6'h00, 0, 5'd1, 5'd2, 32'd8, 32'd9, 32'd0);
    #1;
    tests++; if (IdReady !== 1'b1) begin fails++; $display("FAIL flush_idready_free got %0b exp 1", IdReady); end
    step();
    Flush = 0; IdValid = 0;
    tests++; if (ExValid !== 1'b0 || IllegalOp !== 1'b0) begin fails++; $display("FAIL flush_drop got vld %0b ill %0b exp 0 0", ExValid, IllegalOp); end
  endtask

  task automatic test_back_to_back();
    int run = 0;
    ExReady = 1;
    for (int i = 0; i < 4; i++) begin
      offer(2'b00, 6'h00, 0, 5'(i + 1), 5'd0, 32'h100 + 32'(i), 32'd0, 32'd0);
      step();
      tests++; if (ExValid !== 1'b1 || DataIn1 !== 32'h100 + 32'(i)) begin fails++; $display("FAIL b2b_%0d got vld %0b d1 %h exp 1 %h", i, ExValid, DataIn1, 32'h100 + 32'(i)); end
      if (ExValid === 1'b1) run++;
    end
    IdValid = 0;
    step();
    tests++; if (run != 4 || ExValid !== 1'b0) begin fails++; $display("FAIL b2b_run got %0d vld %0b exp 4 0", run, ExValid); end
  endtask

  task automatic test_rst_mid_stall();
    offer(2'b10, 6'h03, 1, 5'd7, 5'd8, 32'h55, 32'h66, 32'h99);
    step();
    IdValid = 0; ExReady = 0;
    step();
    tests++; if (Sel !== 4'd15 || IllegalOp !== 1'b1 || DataIn2 !== 32'h99) begin fails++; $display("FAIL rst_pre got sel %0d ill %0b d2 %h exp 15 1 99", Sel, IllegalOp, DataIn2); end
    Rst_n = 0;
    step();
    Rst_n = 1;
    #1;
    tests++; if (ExValid !== 1'b0 || IdReady !== 1'b1) begin fails++; $display("FAIL rst_mid_hs got vld %0b rdy %0b exp 0 1", ExValid, IdReady); end
    tests++; if (Sel !== 4'd0 || IllegalOp !== 1'b0) begin fails++; $display("FAIL rst_mid_ctl got sel %0d ill %0b exp 0 0", Sel, IllegalOp); end
    tests++; if (DataIn1 !== 32'd0 || DataIn2 !== 32'd0) begin fails++; $display("FAIL rst_mid_data got %h %h exp 0 0", DataIn1, DataIn2); end
  endtask

  initial begin
    test_reset();
    test_rtype_add();
    test_forward();
    test_stall_refresh();
    test_decode();
    test_flush();
    test_back_to_back();
    test_rst_mid_stall();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
